universal_shift_reg_n: RTL and testbench

//  Parametrised universal shift register with serial in/out and shift-progress tracking.

---
 rtl/usr_pkg.sv | 25 ++
 rtl/usr_shift_counter.sv | 39 +++
 rtl/universal_shift_reg_n.sv | 68 ++++++
 tb/tb_universal_shift_reg_n.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared op encoding for the universal shift register and its bench.
// USR_ROTATE_EN selects whether rotate codes move data and count as shifts.
package usr_pkg;

    typedef enum logic [2:0] {
        USR_HOLD  = 3'b000,
        USR_SHR   = 3'b001,
        USR_SHL   = 3'b010,
        USR_LOAD  = 3'b011,
        USR_ROR   = 3'b100,
        USR_ROL   = 3'b101,
        USR_ZERO  = 3'b110,
        USR_HOLD2 = 3'b111
    } usr_op_e;

    // True for every op that moves data one position and advances the count.
    function automatic logic usr_is_step(input usr_op_e op);
`ifdef USR_ROTATE_EN
        return (op == USR_SHR) || (op == USR_SHL) || (op == USR_ROR) || (op == USR_ROL);
`else
        return (op == USR_SHR) || (op == USR_SHL);
`endif
    endfunction

endpackage

// File: rtl/usr_shift_counter.sv
// Shift-progress tracker: busy from load until WIDTH steps, one-cycle done pulse.
module usr_shift_counter #(
    parameter int WIDTH = 4,
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    input  logic step,
    output logic busy,
    output logic done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // a reload while busy restarts the count without finishing
                cnt  <= '0;
                busy <= 1'b1;
            end else if (step && busy) begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    cnt  <= '0;
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/universal_shift_reg_n.sv
// Universal shift register: load/shift/rotate/zero with shift-progress flags.
// Rotate codes are live only when USR_ROTATE_EN is defined; otherwise they hold.
module universal_shift_reg_n
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] parin,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] out,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    usr_op_e          op;
    logic [WIDTH-1:0] q, nxt;
    logic             start, step, cnt_clr;

    assign op = usr_op_e'(sel);

    always_comb begin
        nxt = q;
        case (op)
            USR_SHR:  nxt = {sin_r, q[WIDTH-1:1]};
            USR_SHL:  nxt = {q[WIDTH-2:0], sin_l};
            USR_LOAD: nxt = parin;
`ifdef USR_ROTATE_EN
            USR_ROR:  nxt = {q[0], q[WIDTH-1:1]};
            USR_ROL:  nxt = {q[WIDTH-2:0], q[WIDTH-1]};
`endif
            USR_ZERO: nxt = '0;
            default:  nxt = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (en)
            q <= nxt;
    end

    // the zero op abandons any word in flight, same as a reset of the tracker
    assign start   = en && (op == USR_LOAD);
    assign step    = en && usr_is_step(op);
    assign cnt_clr = clr || (en && (op == USR_ZERO));

    usr_shift_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .clr   (cnt_clr),
        .start (start),
        .step  (step),
        .busy  (busy),
        .done  (done)
    );

    assign out    = q;
    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg_n.sv
// Directed scoreboard bench for universal_shift_reg_n at WIDTH=4.
module tb_universal_shift_reg_n;
    import usr_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clr, en, sin_r, sin_l;
    logic [2:0]   sel;
    logic [W-1:0] parin, out;
    logic         sout_r, sout_l, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] o;
        logic         b;
        logic         d;
    } exp_t;

    exp_t sb[$];

    universal_shift_reg_n #(.WIDTH(W)) dut (
        .clk(clk), .clr(clr), .en(en), .sel(sel), .parin(parin),
        .sin_r(sin_r), .sin_l(sin_l), .out(out), .sout_r(sout_r),
        .sout_l(sout_l), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk();
        exp_t x;
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL scoreboard_empty got 0 entries exp >=1");
        end
        if (sb.size() != 0) begin
            x = sb.pop_front();
            n_cmp++;
            assert (out === x.o) else begin
                n_err++; $error("FAIL %s out got %b exp %b", x.tag, out, x.o);
            end
            n_cmp++;
            assert (busy === x.b) else begin
                n_err++; $error("FAIL %s busy got %b exp %b", x.tag, busy, x.b);
            end
            n_cmp++;
            assert (done === x.d) else begin
                n_err++; $error("FAIL %s done got %b exp %b", x.tag, done, x.d);
            end
            n_cmp++;
            assert (sout_r === x.o[0] && sout_l === x.o[W-1]) else begin
                n_err++; $error("FAIL %s sout got %b%b exp %b%b", x.tag, sout_l, sout_r, x.o[W-1], x.o[0]);
            end
        end
    endtask

    // Drive one cycle of stimulus, queue its expected result, check after the edge.
    task automatic drv(input logic c, input logic e, input usr_op_e s, input logic [W-1:0] p,
                       input logic sr, input logic sl, input string tag,
                       input logic [W-1:0] eo, input logic eb, input logic ed);
        exp_t x;
        @(negedge clk);
        clr = c; en = e; sel = s; parin = p; sin_r = sr; sin_l = sl;
        x.tag = tag; x.o = eo; x.b = eb; x.d = ed;
        sb.push_back(x);
        @(posedge clk);
        #1;
        chk();
    endtask

    initial begin
        logic [W-1:0] ror_o, rol_o;
        logic         rot_done, rot_busy;
`ifdef USR_ROTATE_EN
        ror_o = 4'b1101; rol_o = 4'b1011; rot_busy = 1'b0; rot_done = 1'b1;
`else
        ror_o = 4'b1011; rol_o = 4'b1011; rot_busy = 1'b1; rot_done = 1'b0;
`endif
        clr = 1'b1; en = 1'b0; sel = 3'b000; parin = '0; sin_r = 1'b0; sin_l = 1'b0;

        drv(1, 1, USR_LOAD, 4'b1111, 1, 1, "reset",      4'b0000, 0, 0);

        // full shift-right of a loaded word
        drv(0, 1, USR_LOAD, 4'b1011, 0, 0, "load",       4'b1011, 1, 0);
        drv(0, 1, USR_SHR,  4'b0000, 0, 0, "shr1",       4'b0101, 1, 0);
        drv(0, 1, USR_SHR,  4'b0000, 0, 0, "shr2",       4'b0010, 1, 0);
        drv(0, 1, USR_SHR,  4'b0000, 0, 0, "shr3",       4'b0001, 1, 0);
        drv(0, 1, USR_SHR,  4'b0000, 0, 0, "shr4",       4'b0000, 0, 1);
        drv(0, 1, USR_HOLD, 4'b0000, 0, 0, "after_done", 4'b0000, 0, 0);

        // shift left, enable low holds, count resumes at 1
        drv(0, 1, USR_LOAD, 4'b1011, 0, 0, "load_l",     4'b1011, 1, 0);
        drv(0, 1, USR_SHL,  4'b0000, 0, 1, "shl1",       4'b0111, 1, 0);
        drv(0, 0, USR_SHL,  4'b0000, 0, 1, "en0_hold",   4'b0111, 1, 0);
        drv(0, 1, USR_SHL,  4'b0000, 0, 1, "shl2",       4'b1111, 1, 0);
        drv(0, 1, USR_SHL,  4'b0000, 0, 1, "shl3",       4'b1111, 1, 0);
        drv(0, 1, USR_SHL,  4'b0000, 0, 1, "shl4",       4'b1111, 0, 1);
        drv(0, 1, USR_SHR,  4'b0000, 1, 0, "idle_shr1",  4'b1111, 0, 0);
        drv(0, 1, USR_SHR,  4'b0000, 0, 0, "idle_shr2",  4'b0111, 0, 0);

        // rotate codes, configuration dependent
        drv(0, 1, USR_LOAD, 4'b1011, 0, 0, "load_r",     4'b1011, 1, 0);
        drv(0, 1, USR_ROR,  4'b0000, 0, 0, "ror",        ror_o,   1, 0);
        drv(0, 1, USR_ROL,  4'b0000, 0, 0, "rol",        rol_o,   1, 0);
        drv(0, 1, USR_SHR,  4'b0000, 0, 0, "rot_shr1",   4'b0101, 1, 0);
        drv(0, 1, USR_SHR,  4'b0000, 0, 0, "rot_shr2",   4'b0010, rot_busy, rot_done);

        // reload while busy restarts the count
        drv(0, 1, USR_LOAD, 4'b1011, 0, 0, "load_a",     4'b1011, 1, 0);
        drv(0, 1, USR_SHR,  4'b0000, 0, 0, "pre_rl",     4'b0101, 1, 0);
        drv(0, 1, USR_LOAD, 4'b0110, 0, 0, "reload",     4'b0110, 1, 0);
        drv(0, 1, USR_HOLD2,4'b0000, 1, 1, "hold2",      4'b0110, 1, 0);
        drv(0, 1, USR_SHR,  4'b0000, 1, 0, "rl_shr1",    4'b1011, 1, 0);
        drv(0, 1, USR_SHR,  4'b0000, 1, 0, "rl_shr2",    4'b1101, 1, 0);
        drv(0, 1, USR_SHR,  4'b0000, 1, 0, "rl_shr3",    4'b1110, 1, 0);
        drv(0, 1, USR_SHR,  4'b0000, 1, 0, "rl_shr4",    4'b1111, 0, 1);

        // zero op: ignored under en=0, otherwise clears data and tracker
        drv(0, 1, USR_LOAD, 4'b1011, 0, 0, "load_z",     4'b1011, 1, 0);
        drv(0, 1, USR_SHR,  4'b0000, 0, 0, "z_shr",      4'b0101, 1, 0);
        drv(0, 0, USR_ZERO, 4'b0000, 0, 0, "zero_en0",   4'b0101, 1, 0);
        drv(0, 1, USR_ZERO, 4'b0000, 0, 0, "zero",       4'b0000, 0, 0);
        drv(0, 1, USR_SHR,  4'b0000, 1, 0, "zi_shr1",    4'b1000, 0, 0);
        drv(0, 1, USR_SHR,  4'b0000, 1, 0, "zi_shr2",    4'b1100, 0, 0);
        drv(0, 1, USR_SHR,  4'b0000, 1, 0, "zi_shr3",    4'b1110, 0, 0);
        drv(0, 1, USR_SHR,  4'b0000, 1, 0, "zi_shr4",    4'b1111, 0, 0);

        // enable low on the final shift defers done
        drv(0, 1, USR_LOAD, 4'b1011, 0, 0, "load_e",     4'b1011, 1, 0);
        drv(0, 1, USR_SHR,  4'b0000, 0, 0, "e_shr1",     4'b0101, 1, 0);
        drv(0, 1, USR_SHR,  4'b0000, 0, 0, "e_shr2",     4'b0010, 1, 0);
        drv(0, 1, USR_SHR,  4'b0000, 0, 0, "e_shr3",     4'b0001, 1, 0);
        drv(0, 0, USR_SHR,  4'b0000, 0, 0, "e_en0",      4'b0001, 1, 0);
        drv(0, 1, USR_SHR,  4'b0000, 0, 0, "e_shr4",     4'b0000, 0, 1);

        // clr beats a shift that would otherwise complete the word
        drv(0, 1, USR_LOAD, 4'b1011, 0, 0, "load_c",     4'b1011, 1, 0);
        drv(0, 1, USR_SHR,  4'b0000, 0, 0, "c_shr1",     4'b0101, 1, 0);
        drv(0, 1, USR_SHR,  4'b0000, 0, 0, "c_shr2",     4'b0010, 1, 0);
        drv(0, 1, USR_SHR,  4'b0000, 0, 0, "c_shr3",     4'b0001, 1, 0);
        drv(1, 1, USR_SHR,  4'b0000, 1, 0, "clr_shift",  4'b0000, 0, 0);
        drv(0, 1, USR_SHR,  4'b0000, 0, 0, "post_clr",   4'b0000, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
